// File: rtl/deser_pkg.sv
// deser_pkg: shared FSM state type and shift helper for the deserializer
package deser_pkg;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} deser_state_t;
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] shift_in(input logic [MAX_W-1:0] word, input logic b, input logic msb_first, input int width);
    return msb_first ? {word[MAX_W-2:0], b} : ((word >> 1) | (MAX_W'(b) << (width - 1)));
  endfunction
endpackage

// File: rtl/deser_shift_reg.sv
// deser_shift_reg: serial shifter with bit counter and selectable direction
module deser_shift_reg
  import deser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MSB_FIRST = 1,
  parameter int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             data_in,
  output logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] next_word,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] word_q;
  logic [CW-1:0] count_q;
  logic [MAX_W-1:0] nxt;
  logic unused_hi;
  assign nxt = shift_in(MAX_W'(word_q), data_in, MSB_FIRST != 0, WIDTH);
  assign next_word = nxt[WIDTH-1:0];
  assign unused_hi = ^nxt[MAX_W-1:WIDTH];
  assign word = word_q;
  assign count = count_q;
  // clear wins over shift so a completed word leaves the shifter empty
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word_q <= '0;
      count_q <= '0;
    end else if (shift_en) begin
      word_q <= next_word;
      count_q <= count_q + CW'(1);
    end
  end
endmodule

// File: rtl/param_deserializer.sv
// param_deserializer: serial-to-parallel word builder with double-buffered ready/ack output
module param_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MSB_FIRST = 1,
  parameter int CW = $clog2(WIDTH + 1)
) (
  input  logic             clock_100k,
  input  logic             reset,
  input  logic             data_in,
  input  logic             write_in,
  input  logic             ack_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_ready,
  output logic             status_out,
  output logic             overrun,
  output logic [CW-1:0]    bit_count
);
  deser_state_t state_q, state_d;
  logic [WIDTH-1:0] data_out_q, data_out_d, word, next_word;
  logic data_ready_q, data_ready_d, status_q, status_d, overrun_q, overrun_d;
  logic accept, ack, done, xfer;
  deser_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST), .CW(CW)) u_shift (
    .clk(clock_100k),
    .rst(reset),
    .shift_en(accept),
    .clear(xfer),
    .data_in(data_in),
    .word(word),
    .next_word(next_word),
    .count(bit_count)
  );
  assign accept = write_in && state_q != FULL;
  assign ack = ack_in && data_ready_q;
  assign done = accept && bit_count == CW'(WIDTH - 1);
  assign xfer = (state_q == FULL && ack) || (done && (!data_ready_q || ack_in));
  assign data_out_d = xfer ? (state_q == FULL ? word : next_word) : ack ? '0 : data_out_q;
  assign data_ready_d = xfer || (data_ready_q && !ack_in);
  assign state_d = xfer ? EMPTY : done ? FULL : accept ? PARTIAL : state_q;
  assign status_d = state_d != EMPTY || data_ready_d;
  assign overrun_d = write_in && state_q == FULL;
  assign data_out = data_out_q;
  assign data_ready = data_ready_q;
  assign status_out = status_q;
  assign overrun = overrun_q;
  // shifter FSM and registered output slot, all cleared by reset
  always_ff @(posedge clock_100k) begin
    if (reset) begin
      state_q <= EMPTY;
      data_out_q <= '0;
      data_ready_q <= 1'b0;
      status_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_out_q <= data_out_d;
      data_ready_q <= data_ready_d;
      status_q <= status_d;
      overrun_q <= overrun_d;
    end
  end
endmodule

// File: tb/tb_param_deserializer.sv
// tb_param_deserializer: three configurations driven in parallel against a bit-queue model
module tb_param_deserializer;
  logic clk = 1'b0, reset = 1'b1, data_in = 1'b0, write_in = 1'b0, ack_in = 1'b0;
  logic [7:0] do0, do1;
  logic [11:0] do2;
  logic [3:0] bc0, bc1, bc2;
  logic rdy[3], st[3], ov[3];
  logic [31:0] dout[3], bc[3];
  int checks = 0, errors = 0;
  int wd[3] = '{8, 8, 12};
  bit msb[3] = '{1'b1, 1'b0, 1'b1};
  bit pb[3][16];
  int pn[3];
  logic [31:0] mo[3];
  bit mr[3], mov[3];
  bit started = 1'b0;

  always #5 clk = ~clk;

  param_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut0 (.clock_100k(clk), .reset(reset), .data_in(data_in), .write_in(write_in), .ack_in(ack_in),
    .data_out(do0), .data_ready(rdy[0]), .status_out(st[0]), .overrun(ov[0]), .bit_count(bc0));
  param_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut1 (.clock_100k(clk), .reset(reset), .data_in(data_in), .write_in(write_in), .ack_in(ack_in),
    .data_out(do1), .data_ready(rdy[1]), .status_out(st[1]), .overrun(ov[1]), .bit_count(bc1));
  param_deserializer #(.WIDTH(12), .MSB_FIRST(1)) dut2 (.clock_100k(clk), .reset(reset), .data_in(data_in), .write_in(write_in), .ack_in(ack_in),
    .data_out(do2), .data_ready(rdy[2]), .status_out(st[2]), .overrun(ov[2]), .bit_count(bc2));

  assign dout[0] = {24'b0, do0};
  assign dout[1] = {24'b0, do1};
  assign dout[2] = {20'b0, do2};
  assign bc[0] = {28'b0, bc0};
  assign bc[1] = {28'b0, bc1};
  assign bc[2] = {28'b0, bc2};

  function automatic logic [31:0] assemble(int k);
    logic [31:0] w = '0;
    for (int i = 0; i < wd[k]; i++)
      w = msb[k] ? ((w << 1) | 32'(pb[k][i])) : (w | (32'(pb[k][i]) << i));
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic w, input logic d, input logic a);
    write_in = w;
    data_in = d;
    ack_in = a;
    @(negedge clk);
  endtask

  task automatic send8(input logic [7:0] v, input logic ack_last);
    for (int i = 0; i < 8; i++) cyc(1'b1, v[7-i], ack_last && i == 7);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (reset) begin
          pn[k] = 0; mo[k] = '0; mr[k] = 1'b0; mov[k] = 1'b0;
        end else begin
          mov[k] = write_in && pn[k] == wd[k];
          if (write_in && pn[k] < wd[k]) begin
            pb[k][pn[k]] = data_in;
            pn[k]++;
          end
          if (pn[k] == wd[k] && (!mr[k] || ack_in)) begin
            mo[k] = assemble(k); mr[k] = 1'b1; pn[k] = 0;
          end else if (ack_in && mr[k]) begin
            mr[k] = 1'b0; mo[k] = '0;
          end
        end
      end
      started = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("data_out[%0d]", k), dout[k], mo[k]);
        chk($sformatf("data_ready[%0d]", k), 32'(rdy[k]), 32'(mr[k]));
        chk($sformatf("status_out[%0d]", k), 32'(st[k]), 32'(pn[k] != 0 || mr[k]));
        chk($sformatf("overrun[%0d]", k), 32'(ov[k]), 32'(mov[k]));
        chk($sformatf("bit_count[%0d]", k), bc[k], 32'(pn[k]));
      end
    end
  end

  initial begin
    logic [11:0] v12;
    @(negedge clk);
    chk("reset data_out", dout[0], 32'h0);
    chk("reset data_ready", 32'(rdy[0]), 32'h0);
    reset = 1'b0;
    send8(8'hB2, 1'b0);
    chk("t1 msb word", dout[0], 32'hB2);
    chk("t1 msb ready", 32'(rdy[0]), 32'h1);
    chk("t1 msb count", bc[0], 32'h0);
    chk("t1 msb status", 32'(st[0]), 32'h1);
    chk("t2 lsb word", dout[1], 32'h4D);
    send8(8'h0F, 1'b0);
    chk("t3 full count", bc[0], 32'h8);
    chk("t3 held word", dout[0], 32'hB2);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t3 overrun pulse", 32'(ov[0]), 32'h1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t3 overrun clear", 32'(ov[0]), 32'h0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("t3 transfer word", dout[0], 32'h0F);
    chk("t3 ready held", 32'(rdy[0]), 32'h1);
    chk("t3 count cleared", bc[0], 32'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, i[0] ? 1'b0 : 1'b1, i == 7);
      chk("t4 ready stays", 32'(rdy[0]), 32'h1);
      chk("t4 no overrun", 32'(ov[0]), 32'h0);
    end
    chk("t4 direct word", dout[0], 32'hAA);
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("t5 partial count", bc[0], 32'h5);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    chk("t5 reset count", bc[0], 32'h0);
    chk("t5 reset status", 32'(st[0]), 32'h0);
    send8(8'h3C, 1'b0);
    chk("t5 word after reset", dout[0], 32'h3C);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("t5 reset data_out", dout[0], 32'h0);
    chk("t5 reset ready", 32'(rdy[0]), 32'h0);
    send8(8'h3C, 1'b0);
    chk("t5 clean word", dout[0], 32'h3C);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    v12 = 12'hA5C;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, v12[11-i], 1'b0);
      for (int g = 0; g < 3; g++) cyc(1'b0, 1'b0, i == 0 && g == 0);
      if (i == 0) begin
        chk("t6 stray ack ready", 32'(rdy[2]), 32'h0);
        chk("t6 stray ack count", bc[2], 32'h1);
      end
    end
    chk("t6 word12", dout[2], 32'hA5C);
    chk("t6 ready12", 32'(rdy[2]), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
